// File: rtl/ps2_key_decoder_if.sv
// Signal bundle between a PS/2 keyboard port and the key decoder.
// master drives the raw PS/2 lines; slave is the decoder producing key outputs.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] keyboard;
    logic       key_pulse;
    logic       frame_error;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keyboard,
        input  key_pulse,
        input  frame_error
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keyboard,
        output key_pulse,
        output frame_error
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames scan codes and maps W/D/S/A/SPACE onto a held
// 4-bit key code, with a press strobe and a frame-error strobe.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned TO_W           = 18
) (
    input logic               clk,
    input logic               reset_n,
    ps2_key_decoder_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StRecv} state_e;

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

    logic       clk_meta_q, clk_sync_q, clk_prev_q;
    logic       data_meta_q, data_sync_q;
    logic       fall;

    state_e          state_q, state_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [8:0]      shreg_q, shreg_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            byte_valid_q, byte_valid_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            ferr_q, ferr_d;

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [3:0] kb_q, kb_d;
    logic       pulse_q, pulse_d;
    logic [3:0] mapped;

    // Synchronizers preset high so reset never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= bus.ps2_clk;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= bus.ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q;

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_d = 1'b0;
        rx_byte_d    = rx_byte_q;
        ferr_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                to_cnt_d = '0;
                if (fall) begin
                    if (!data_sync_q) begin
                        state_d  = StRecv;
                        bitcnt_d = 4'd1;
                        shreg_d  = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            StRecv: begin
                if (fall) begin
                    to_cnt_d = '0;
                    if (bitcnt_q == 4'd10) begin
                        // shreg holds data[7:0] plus parity in bit 8; odd overall parity required
                        if ((^shreg_q) && data_sync_q) begin
                            byte_valid_d = 1'b1;
                            rx_byte_d    = shreg_q[7:0];
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d  = StIdle;
                        bitcnt_d = '0;
                    end else begin
                        shreg_d  = {data_sync_q, shreg_q[8:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else if (to_cnt_q == ToLast) begin
                    ferr_d   = 1'b1;
                    state_d  = StIdle;
                    bitcnt_d = '0;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        unique case (rx_byte_q)
            8'h1D:   mapped = 4'b0001;
            8'h23:   mapped = 4'b0010;
            8'h1B:   mapped = 4'b0011;
            8'h1C:   mapped = 4'b0100;
            8'h29:   mapped = 4'b0101;
            default: mapped = 4'b0000;
        endcase
    end

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        kb_d    = kb_q;
        pulse_d = 1'b0;
        if (byte_valid_q) begin
            if (rx_byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (rx_byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (ext_q) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else if (brk_q) begin
                // Releasing a key other than the held one leaves the held key alone.
                if ((mapped != 4'b0000) && (mapped == kb_q)) begin
                    kb_d = 4'b0000;
                end
                brk_d = 1'b0;
            end else if (mapped != 4'b0000) begin
                kb_d    = mapped;
                pulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            rx_byte_q    <= '0;
            ferr_q       <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            kb_q         <= '0;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            rx_byte_q    <= rx_byte_d;
            ferr_q       <= ferr_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            kb_q         <= kb_d;
            pulse_q      <= pulse_d;
        end
    end

    assign bus.keyboard    = kb_q;
    assign bus.key_pulse   = pulse_q;
    assign bus.frame_error = ferr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: PS/2 frames in, held key / strobes checked
// against a queue of expected key codes and per-frame strobe counts.
module tb_ps2_key_decoder;

    localparam int unsigned TimeoutCycles = 200;
    localparam int unsigned ToW           = 8;
    localparam int          Half          = 20;

    logic clk;
    logic reset_n;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (TimeoutCycles),
        .TO_W           (ToW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         pulse_cnt = 0;
    int         ferr_cnt = 0;
    logic       pulse_prev = 1'b0;
    logic       ferr_prev = 1'b0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every key_pulse consumes one expected key code.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.key_pulse) begin
                pulse_cnt++;
                check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("pulse_kb", 32'(bus.keyboard), 32'(exp_q.pop_front()));
                check("pulse_width", 32'(pulse_prev), 32'd0);
            end
            if (bus.frame_error) begin
                ferr_cnt++;
                check("ferr_width", 32'(ferr_prev), 32'd0);
            end
        end
        pulse_prev <= bus.key_pulse;
        ferr_prev  <= bus.frame_error;
    end

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = bits[i];
            repeat (Half) @(posedge clk);
            bus.ps2_clk = 1'b0;
            repeat (Half) @(posedge clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad);
        logic par;
        par = bad ? (^b) : ~(^b);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic frame(input string tag, input logic [7:0] b, input bit bad,
                         input logic [3:0] exp_kb, input int exp_p, input int exp_fe);
        int p0;
        int f0;
        p0 = pulse_cnt;
        f0 = ferr_cnt;
        if (exp_p > 0) exp_q.push_back(exp_kb);
        send_bits(frame_bits(b, bad), 11);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check({tag, "_kb"}, 32'(bus.keyboard), 32'(exp_kb));
        check({tag, "_pulses"}, 32'(pulse_cnt - p0), 32'(exp_p));
        check({tag, "_ferr"}, 32'(ferr_cnt - f0), 32'(exp_fe));
    endtask

    initial begin
        int f0;
        reset_n      = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_kb", 32'(bus.keyboard), 32'd0);
        check("rst_pulse", 32'(bus.key_pulse), 32'd0);
        check("rst_ferr", 32'(bus.frame_error), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        frame("w_make", 8'h1D, 1'b0, 4'b0001, 1, 0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("w_held", 32'(bus.keyboard), 32'd1);
        frame("w_brk_f0", 8'hF0, 1'b0, 4'b0001, 0, 0);
        frame("w_brk", 8'h1D, 1'b0, 4'b0000, 0, 0);

        frame("sp_make", 8'h29, 1'b0, 4'b0101, 1, 0);
        frame("a_make", 8'h1C, 1'b0, 4'b0100, 1, 0);
        frame("sp_brk_f0", 8'hF0, 1'b0, 4'b0100, 0, 0);
        frame("sp_brk", 8'h29, 1'b0, 4'b0100, 0, 0);
        frame("a_brk_f0", 8'hF0, 1'b0, 4'b0100, 0, 0);
        frame("a_brk", 8'h1C, 1'b0, 4'b0000, 0, 0);

        frame("d_badpar", 8'h23, 1'b1, 4'b0000, 0, 1);
        frame("d_make", 8'h23, 1'b0, 4'b0010, 1, 0);
        frame("d_brk_f0", 8'hF0, 1'b0, 4'b0010, 0, 0);
        frame("d_brk", 8'h23, 1'b0, 4'b0000, 0, 0);

        frame("ext_e0", 8'hE0, 1'b0, 4'b0000, 0, 0);
        frame("ext_1d", 8'h1D, 1'b0, 4'b0000, 0, 0);
        frame("q_make", 8'h15, 1'b0, 4'b0000, 0, 0);

        // A lone falling edge with data high is a bad start bit.
        f0 = ferr_cnt;
        send_bits(11'h7FF, 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bad_start_ferr", 32'(ferr_cnt - f0), 32'd1);

        f0 = ferr_cnt;
        send_bits(frame_bits(8'h1B, 1'b0), 5);
        repeat (TimeoutCycles + 50) @(posedge clk);
        @(negedge clk);
        check("timeout_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("timeout_kb", 32'(bus.keyboard), 32'd0);
        frame("s_make", 8'h1B, 1'b0, 4'b0011, 1, 0);

        send_bits(frame_bits(8'h1C, 1'b0), 5);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_kb", 32'(bus.keyboard), 32'd0);
        check("midrst_pulse", 32'(bus.key_pulse), 32'd0);
        check("midrst_ferr", 32'(bus.frame_error), 32'd0);
        repeat (3) @(posedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        frame("post_rst_w", 8'h1D, 1'b0, 4'b0001, 1, 0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
